// File: rtl/prog_loader.sv
// Boot-time program loader: parses SYNC/LEN/payload[/CHK] frames from a byte stream,
// writes the payload into instruction memory from address 0 and holds the CPU until done.
// Optional checksum byte and verification enabled by defining CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              ins_wr_en,
    output logic [ADDR_W-1:0] ins_wr_addr,
    output logic [DATA_W-1:0] ins_wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_LOAD = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_rx_ready;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_cpu_hold;
    logic               r_load_done;
    logic               r_load_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;

    logic               w_rx_ready_d;
    logic               w_wr_en_d;
    logic [ADDR_W-1:0]  w_wr_addr_d;
    logic [DATA_W-1:0]  w_wr_data_d;
    logic               w_cpu_hold_d;
    logic               w_load_done_d;
    logic               w_load_err_d;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [ADDR_W-1:0]  w_addr_d;

    logic               w_accept;
    logic               w_sync;
    logic               w_last_wr;

`ifdef CHECKSUM_EN
    logic [7:0]         r_sum;
    logic [7:0]         w_sum_d;
    logic               w_sum_ok;

    assign w_sum_ok = (8'(r_sum + rx_data) == 8'd0);
`endif

    assign w_accept  = rx_valid && r_rx_ready;
    assign w_sync    = w_accept && (rx_data == SYNC_BYTE);
    // The write cycle of the final payload byte: counter already decremented to zero.
    assign w_last_wr = (r_state == S_LOAD) && r_wr_en && (r_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_sync) w_state_nxt = S_LEN;
            S_LEN:  if (w_accept) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_last_wr) begin
`ifdef CHECKSUM_EN
                    w_state_nxt = S_CHK;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CHK:  if (w_accept) w_state_nxt = w_sum_ok ? S_DONE : S_ERR;
`endif
            S_DONE: if (w_sync) w_state_nxt = S_LEN;
            S_ERR:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values, registered below
    always_comb begin
        w_rx_ready_d  = 1'b1;
        w_wr_en_d     = 1'b0;
        w_wr_addr_d   = r_wr_addr;
        w_wr_data_d   = r_wr_data;
        w_cpu_hold_d  = (w_state_nxt != S_DONE);
        w_load_done_d = (w_state_nxt == S_DONE);
        w_cnt_d       = r_cnt;
        w_addr_d      = r_addr;
`ifdef CHECKSUM_EN
        w_sum_d       = r_sum;
        w_load_err_d  = r_load_err;
        if (w_sync && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
            w_load_err_d = 1'b0;
        end
        if (w_state_nxt == S_ERR) begin
            w_load_err_d = 1'b1;
        end
`else
        w_load_err_d  = 1'b0;
`endif

        if ((r_state == S_LEN) && w_accept) begin
            w_cnt_d  = (rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : CNT_W'(rx_data);
            w_addr_d = '0;
`ifdef CHECKSUM_EN
            w_sum_d  = 8'd0;
`endif
        end

        // Payload byte: issue the write next cycle and block the stream for that cycle
        if ((r_state == S_LOAD) && w_accept) begin
            w_wr_en_d    = 1'b1;
            w_wr_addr_d  = r_addr;
            w_wr_data_d  = DATA_W'(rx_data);
            w_rx_ready_d = 1'b0;
            w_cnt_d      = r_cnt - CNT_W'(1);
            w_addr_d     = r_addr + ADDR_W'(1);
`ifdef CHECKSUM_EN
            w_sum_d      = 8'(r_sum + rx_data);
`endif
        end

        if (w_state_nxt == S_ERR) begin
            w_rx_ready_d = 1'b0;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_ready  <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= '0;
`ifdef CHECKSUM_EN
            r_sum       <= 8'd0;
`endif
        end else begin
            r_rx_ready  <= w_rx_ready_d;
            r_wr_en     <= w_wr_en_d;
            r_wr_addr   <= w_wr_addr_d;
            r_wr_data   <= w_wr_data_d;
            r_cpu_hold  <= w_cpu_hold_d;
            r_load_done <= w_load_done_d;
            r_load_err  <= w_load_err_d;
            r_cnt       <= w_cnt_d;
            r_addr      <= w_addr_d;
`ifdef CHECKSUM_EN
            r_sum       <= w_sum_d;
`endif
        end
    end

    assign rx_ready    = r_rx_ready;
    assign ins_wr_en   = r_wr_en;
    assign ins_wr_addr = r_wr_addr;
    assign ins_wr_data = r_wr_data;
    assign cpu_hold    = r_cpu_hold;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framing, write strobes, hold/done handshake, reset abort,
// 256-byte frames and (when CHECKSUM_EN is defined) checksum pass/fail.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       ins_wr_en;
    logic [7:0] ins_wr_addr;
    logic [7:0] ins_wr_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];

    prog_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .ins_wr_en   (ins_wr_en),
        .ins_wr_addr (ins_wr_addr),
        .ins_wr_data (ins_wr_data),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    // One log entry per cycle the strobe is high; a stretched strobe shows up as extra entries
    always @(negedge clk) begin
        if (ins_wr_en === 1'b1) begin
            wa.push_back(ins_wr_addr);
            wd.push_back(ins_wr_data);
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge with rx_valid low
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_byte_timeout: rx_ready=%b required 1 (byte %02h)", rx_ready, b);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++; if (rx_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_tests++; if (ins_wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", ins_wr_en); end
        n_tests++; if (ins_wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", ins_wr_addr); end
        n_tests++; if (ins_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", ins_wr_data); end
        n_tests++; if (cpu_hold !== 1'b1)     begin n_fail++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        n_tests++; if (load_done !== 1'b0)    begin n_fail++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        n_tests++; if (load_err !== 1'b0)     begin n_fail++; $display("FAIL reset_load_err: got %b want 0", load_err); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum_good();
        int base;
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h9A);
        #1;
        n_tests++; if (wa.size() !== base + 3) begin n_fail++; $display("FAIL good_write_count: got %0d want %0d", wa.size() - base, 3); end
        else begin
            n_tests++; if (wa[base] !== 8'h00 || wd[base] !== 8'h11) begin n_fail++; $display("FAIL good_write0: got %h:%h want 00:11", wa[base], wd[base]); end
            n_tests++; if (wa[base+1] !== 8'h01 || wd[base+1] !== 8'h22) begin n_fail++; $display("FAIL good_write1: got %h:%h want 01:22", wa[base+1], wd[base+1]); end
            n_tests++; if (wa[base+2] !== 8'h02 || wd[base+2] !== 8'h33) begin n_fail++; $display("FAIL good_write2: got %h:%h want 02:33", wa[base+2], wd[base+2]); end
        end
        n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL good_load_done: got %b want 1", load_done); end
        n_tests++; if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL good_cpu_hold: got %b want 0", cpu_hold); end
        n_tests++; if (load_err !== 1'b0)  begin n_fail++; $display("FAIL good_load_err: got %b want 0", load_err); end
    endtask

    task automatic test_checksum_bad();
        int base;
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h00);
        #1;
        n_tests++; if (wa.size() !== base + 3) begin n_fail++; $display("FAIL bad_write_count: got %0d want 3", wa.size() - base); end
        n_tests++; if (load_err !== 1'b1)  begin n_fail++; $display("FAIL bad_load_err: got %b want 1", load_err); end
        n_tests++; if (cpu_hold !== 1'b1)  begin n_fail++; $display("FAIL bad_cpu_hold: got %b want 1", cpu_hold); end
        n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL bad_load_done: got %b want 0", load_done); end
        n_tests++; if (rx_ready !== 1'b0)  begin n_fail++; $display("FAIL bad_err_rx_ready: got %b want 0", rx_ready); end
        @(negedge clk);
        n_tests++; if (load_err !== 1'b1)  begin n_fail++; $display("FAIL bad_err_sticky: got %b want 1", load_err); end
        n_tests++; if (rx_ready !== 1'b1)  begin n_fail++; $display("FAIL bad_idle_rx_ready: got %b want 1", rx_ready); end
        send_byte(8'hA5);
        n_tests++; if (load_err !== 1'b0)  begin n_fail++; $display("FAIL bad_err_cleared: got %b want 0", load_err); end
        send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h9A);
        n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL bad_recover_done: got %b want 1", load_done); end
        n_tests++; if (load_err !== 1'b0)  begin n_fail++; $display("FAIL bad_recover_err: got %b want 0", load_err); end
    endtask
`else
    task automatic test_frame_nochk();
        int base;
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h7E); send_byte(8'h7F);
        #1;
        n_tests++; if (ins_wr_en !== 1'b1 || ins_wr_addr !== 8'h01 || ins_wr_data !== 8'h7F)
            begin n_fail++; $display("FAIL nochk_last_write: got en=%b %h:%h want en=1 01:7f", ins_wr_en, ins_wr_addr, ins_wr_data); end
        n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL nochk_done_early: got %b want 0", load_done); end
        @(negedge clk); #1;
        n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL nochk_load_done: got %b want 1", load_done); end
        n_tests++; if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL nochk_cpu_hold: got %b want 0", cpu_hold); end
        n_tests++; if (ins_wr_en !== 1'b0) begin n_fail++; $display("FAIL nochk_strobe_len: got %b want 0", ins_wr_en); end
        n_tests++; if (wa.size() !== base + 2) begin n_fail++; $display("FAIL nochk_write_count: got %0d want 2", wa.size() - base); end
        else begin
            n_tests++; if (wa[base] !== 8'h00 || wd[base] !== 8'h7E) begin n_fail++; $display("FAIL nochk_write0: got %h:%h want 00:7e", wa[base], wd[base]); end
            n_tests++; if (wa[base+1] !== 8'h01 || wd[base+1] !== 8'h7F) begin n_fail++; $display("FAIL nochk_write1: got %h:%h want 01:7f", wa[base+1], wd[base+1]); end
        end
        @(negedge clk);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (wa.size() !== base + 2) begin n_fail++; $display("FAIL nochk_trailing_write: got %0d writes want 2", wa.size() - base); end
        n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL nochk_trailing_done: got %b want 1", load_done); end
        n_tests++; if (load_err !== 1'b0)  begin n_fail++; $display("FAIL nochk_load_err: got %b want 0", load_err); end
        @(negedge clk);
    endtask
`endif

    task automatic test_reload();
        int base;
        base = wa.size();
        send_byte(8'hA5);
        n_tests++; if (cpu_hold !== 1'b1)  begin n_fail++; $display("FAIL reload_cpu_hold: got %b want 1", cpu_hold); end
        n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reload_load_done: got %b want 0", load_done); end
        send_byte(8'h01);
        send_byte(8'h42);
`ifdef CHECKSUM_EN
        send_byte(8'hBE);
`else
        @(negedge clk);
`endif
        #1;
        n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL reload_done: got %b want 1", load_done); end
        n_tests++; if (wa.size() !== base + 1) begin n_fail++; $display("FAIL reload_write_count: got %0d want 1", wa.size() - base); end
        else begin
            n_tests++; if (wa[base] !== 8'h00 || wd[base] !== 8'h42) begin n_fail++; $display("FAIL reload_write0: got %h:%h want 00:42", wa[base], wd[base]); end
        end
        @(negedge clk);
    endtask

    task automatic test_len0();
        int base;
        base = wa.size();
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
`ifdef CHECKSUM_EN
        send_byte(8'h80);
`else
        @(negedge clk);
`endif
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (wa.size() !== base + 256) begin n_fail++; $display("FAIL len0_write_count: got %0d want 256", wa.size() - base); end
        else begin
            for (int i = 0; i < 256; i++) begin
                n_tests++;
                if (wa[base+i] !== 8'(i) || wd[base+i] !== 8'(i)) begin
                    n_fail++; $display("FAIL len0_write%0d: got %h:%h want %h:%h", i, wa[base+i], wd[base+i], 8'(i), 8'(i));
                end
            end
        end
        n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", load_done); end
        n_tests++; if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL len0_cpu_hold: got %b want 0", cpu_hold); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int base;
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (ins_wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_wr_en: got %b want 0", ins_wr_en); end
        n_tests++; if (cpu_hold !== 1'b1)  begin n_fail++; $display("FAIL abort_cpu_hold: got %b want 1", cpu_hold); end
        n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL abort_load_done: got %b want 0", load_done); end
        n_tests++; if (rx_ready !== 1'b1)  begin n_fail++; $display("FAIL abort_rx_ready: got %b want 1", rx_ready); end
        n_tests++; if (ins_wr_addr !== 8'h00) begin n_fail++; $display("FAIL abort_wr_addr: got %h want 00", ins_wr_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_byte(8'h33);
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (wa.size() !== base + 2) begin n_fail++; $display("FAIL abort_write_count: got %0d want 2", wa.size() - base); end
        n_tests++; if (cpu_hold !== 1'b1)  begin n_fail++; $display("FAIL abort_idle_hold: got %b want 1", cpu_hold); end
        n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL abort_idle_done: got %b want 0", load_done); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
`ifdef CHECKSUM_EN
        test_checksum_good();
        test_reload();
        test_checksum_bad();
`else
        test_frame_nochk();
        test_reload();
`endif
        test_len0();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that writes the instruction memory, the write-side counterpart of the processor's instruction fetch path. It accepts a framed byte stream (typically from a UART receiver) over a valid/ready handshake, writes the payload into instruction memory starting at address 0, and holds the processor in reset until a complete, valid image has been written. It sits beside the processor/RAM top level and drives the instruction memory write port and the processor hold line.

## Interface

- ADDR_W, 8, instruction memory address width; fixed at 8 (frame length field is one byte)
- DATA_W, 8, instruction word width
- SYNC_BYTE, 8'hA5, frame start marker
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rx_data  input  8  incoming stream byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte on an edge where rx_valid && rx_ready
- ins_wr_en  output  1  one-cycle instruction memory write strobe
- ins_wr_addr  output  ADDR_W  write address
- ins_wr_data  output  DATA_W  write data
- cpu_hold  output  1  high keeps the processor in reset
- load_done  output  1  high while a valid image is loaded and the processor is released
- load_err  output  1  sticky frame error flag

## Operation

- Frame format: SYNC_BYTE, LEN, LEN payload bytes, then CHK when CHECKSUM_EN is defined. LEN = 0 means 256 bytes.
- States and transitions:
  - IDLE:
    - Sync byte accepted -> LEN.
    - Any other byte is accepted and discarded.
  - LEN: byte accepted -> count register = LEN (0 maps to 256), address = 0 -> LOAD.
  - LOAD: each accepted byte is written to the current address, then the address increments.
    - After the last write, go to CHK (checksum enabled) or DONE (checksum disabled).
  - CHK: byte accepted.
    - If (payload sum + CHK) mod 256 == 0 -> DONE.
    - Otherwise -> ERR.
  - DONE:
    - cpu_hold = 0 and load_done = 1.
    - Non-sync bytes are accepted and discarded.
    - Sync byte -> LEN, with cpu_hold = 1 and load_done = 0 from the following cycle (reload).
  - ERR: load_err = 1 and cpu_hold = 1; goes to IDLE on the next cycle.
- Error flag: load_err stays set until the next sync byte is accepted.
- Arithmetic:
  - 8-bit checksum accumulator, cleared in LEN, wraps mod 256.
  - 9-bit remaining-byte counter.
  - Address increments mod 256.

## Timing

- Reset values: state IDLE, rx_ready = 1, ins_wr_en = 0, ins_wr_addr = 0, ins_wr_data = 0, cpu_hold = 1, load_done = 0, load_err = 0.
- Reset is asynchronous and takes effect mid-frame. No write is issued after reset asserts, and the partial image is abandoned.
- rx_ready:
  - 1 in IDLE, LEN, CHK and DONE.
  - In LOAD, 0 for the one cycle after each payload byte is accepted (the write cycle), giving a throughput of 1 payload byte per 2 cycles.
  - 0 in ERR.
- Payload write: ins_wr_en/addr/data are registered and valid in the cycle after the acceptance edge, for exactly one cycle.
- Checksum disabled: DONE is entered on the edge ending the last write cycle.
- Checksum enabled: DONE or ERR is entered on the CHK acceptance edge.
- cpu_hold falls and load_done rises in the same cycle, the first cycle in DONE.
- An rx_valid held low stalls the FSM indefinitely. There is no timeout.

## Configuration

- CHECKSUM_EN defined:
  - A CHK byte is expected after the payload and verified.
  - A mismatch gives ERR, and the processor stays held.
- CHECKSUM_EN undefined:
  - No CHK byte is consumed, and the checksum logic is removed.
  - load_err is tied to 0.
  - The byte following the payload is treated as IDLE/DONE traffic.

## Test plan

- Reset check: assert reset_n = 0 mid-stream -> all outputs at their reset values immediately.
- Good frame (CHECKSUM_EN): A5 03 11 22 33 9A -> writes 0:11, 1:22, 2:33, each a single-cycle strobe. After the 9A edge, load_done = 1, cpu_hold = 0, load_err = 0.
- Bad checksum: A5 03 11 22 33 00 -> 3 writes, then load_err = 1, cpu_hold = 1, load_done = 0. A following good frame clears load_err and reaches DONE.
- Length 0: A5 00 followed by 256 bytes with a correct CHK -> 256 writes at addresses 0x00..0xFF, with the last address 0xFF and no wrap write to 0x00.
- Abort and reload:
  - Reset pulse after 2 of 3 payload bytes -> no third write, state IDLE, cpu_hold = 1.
  - Sync byte sent while in DONE -> cpu_hold = 1 and load_done = 0 on the next cycle.
- CHECKSUM_EN undefined: A5 02 7E 7F -> writes 0:7E and 1:7F, and load_done rises the cycle after the second write. A subsequent byte 55 is accepted and ignored, producing no write.
